dut_cmd_slave: RTL

//  Downstream consumer of dut_if (slave modport). Samples cmd/adr/data every clk and

---
 rtl/dut_cmd_pkg.sv | 23 ++
 rtl/dut_sat_counter.sv | 28 ++
 rtl/dut_cmd_slave.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dut_cmd_pkg.sv
// Shared definitions for the command slave.
// Holds the command encoding, the clear-sweep FSM states, and the highest
// legal command code. Any command code above CMD_LAST is treated as illegal.
package dut_cmd_pkg;

  localparam int unsigned CMD_WIDTH = 4;

  typedef enum logic [CMD_WIDTH-1:0] {
    NOP = 4'd0,
    WR  = 4'd1,
    RD  = 4'd2,
    INC = 4'd3,
    CLR = 4'd4
  } cmd_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  localparam cmd_e CMD_LAST = CLR;

endpackage

// File: rtl/dut_sat_counter.sv
// Saturating up-counter used for the statistics outputs.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, clears the count
//   inc  in   count one event this cycle
//   cnt  out  current count; sticks at all-ones instead of wrapping
module dut_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/dut_cmd_slave.sv
// Command slave: consumes one bus command per cycle and executes it against a
// 2**ADR_W x DATA_W register array.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   cmd, adr, data        bus command, address and operand (sampled every clk)
//   rsp_valid             one-cycle pulse per executed RD / INC
//   rsp_adr, rsp_data     address and result of the responding command (held)
//   busy                  CLR sweep in progress
//   err                   sticky: illegal command seen or command dropped
//   cnt_wr, cnt_rd        executed WR+INC / RD counts (saturating)
//   cnt_drop              non-NOP commands discarded during a sweep (saturating)
//   cnt_illegal           illegal commands executed outside a sweep (saturating)
// Pipeline: E1 registers the bus; E2 decodes the E1 registers and updates the
// array and response registers on the next edge.
module dut_cmd_slave
  import dut_cmd_pkg::*;
#(
  parameter int unsigned ADR_W  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] data,
  output logic              rsp_valid,
  output logic [ADR_W-1:0]  rsp_adr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  cnt_wr,
  output logic [CNT_W-1:0]  cnt_rd,
  output logic [CNT_W-1:0]  cnt_drop,
  output logic [CNT_W-1:0]  cnt_illegal
);

  localparam int unsigned DEPTH = 2**ADR_W;

  // E1 stage
  logic [CMD_W-1:0]  r_e1_cmd;
  logic [ADR_W-1:0]  r_e1_adr;
  logic [DATA_W-1:0] r_e1_data;

  // storage and sweep FSM
  logic [DATA_W-1:0] r_mem [DEPTH];
  state_e            r_state, w_state_nxt;
  logic [ADR_W-1:0]  r_idx, w_idx_nxt;

  // response / status registers
  logic              r_rsp_valid;
  logic [ADR_W-1:0]  r_rsp_adr;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_err;

  // E2 decode
  logic              w_is_nop, w_is_wr, w_is_rd, w_is_inc, w_is_clr, w_is_ill;
  logic              w_exec, w_drop;
  logic [DATA_W-1:0] w_rd_val, w_inc_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e1_cmd  <= CMD_W'(NOP);
      r_e1_adr  <= '0;
      r_e1_data <= '0;
    end else begin
      r_e1_cmd  <= cmd;
      r_e1_adr  <= adr;
      r_e1_data <= data;
    end
  end

  always_comb begin
    w_is_nop  = (r_e1_cmd == CMD_W'(NOP));
    w_is_wr   = (r_e1_cmd == CMD_W'(WR));
    w_is_rd   = (r_e1_cmd == CMD_W'(RD));
    w_is_inc  = (r_e1_cmd == CMD_W'(INC));
    w_is_clr  = (r_e1_cmd == CMD_W'(CLR));
    w_is_ill  = (r_e1_cmd > CMD_W'(CMD_LAST));
    // everything in E2 is discarded while the sweep owns the array
    w_exec    = (r_state == S_IDLE);
    w_drop    = (r_state == S_CLEAR) && !w_is_nop;
    // combinational read: a RD right after a WR/INC to the same address sees the new value
    w_rd_val  = r_mem[r_e1_adr];
    w_inc_val = w_rd_val + r_e1_data;
  end

  // sweep FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_is_clr) begin
          w_state_nxt = S_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      S_CLEAR: begin
        // index wraps back to 0 on the last entry
        w_idx_nxt = r_idx + ADR_W'(1);
        if (r_idx == '1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else if (r_state == S_CLEAR) begin
      r_mem[r_idx] <= '0;
    end else if (w_is_wr) begin
      r_mem[r_e1_adr] <= r_e1_data;
    end else if (w_is_inc) begin
      r_mem[r_e1_adr] <= w_inc_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_adr   <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_exec && (w_is_rd || w_is_inc);
      if (w_exec && (w_is_rd || w_is_inc)) begin
        r_rsp_adr  <= r_e1_adr;
        r_rsp_data <= w_is_inc ? w_inc_val : w_rd_val;
      end
      if ((w_exec && w_is_ill) || w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  dut_sat_counter #(.W(CNT_W)) u_cnt_wr (
    .clk (clk),
    .rst (rst),
    .inc (w_exec && (w_is_wr || w_is_inc)),
    .cnt (cnt_wr)
  );

  dut_sat_counter #(.W(CNT_W)) u_cnt_rd (
    .clk (clk),
    .rst (rst),
    .inc (w_exec && w_is_rd),
    .cnt (cnt_rd)
  );

  dut_sat_counter #(.W(CNT_W)) u_cnt_drop (
    .clk (clk),
    .rst (rst),
    .inc (w_drop),
    .cnt (cnt_drop)
  );

  dut_sat_counter #(.W(CNT_W)) u_cnt_illegal (
    .clk (clk),
    .rst (rst),
    .inc (w_exec && w_is_ill),
    .cnt (cnt_illegal)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_adr   = r_rsp_adr;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state == S_CLEAR);
  assign err       = r_err;

endmodule
